// File: rtl/alu_mdu_pkg.sv
// Shared definitions for alu_mdu: op codes, FSM states and op-class helpers.
package alu_mdu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SUB    = 5'b00001,
        OP_SLL    = 5'b00010,
        OP_SLT    = 5'b00011,
        OP_SLTU   = 5'b00100,
        OP_XOR    = 5'b00101,
        OP_SRL    = 5'b00110,
        OP_SRA    = 5'b00111,
        OP_OR     = 5'b01000,
        OP_AND    = 5'b01001,
        OP_PASSB  = 5'b01010,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    // Any of MUL/MULH/MULHSU/MULHU
    function automatic logic is_mul(input logic [4:0] op);
        return op[4:2] == 3'b100;
    endfunction

    // Any of DIV/DIVU/REM/REMU
    function automatic logic is_div(input logic [4:0] op);
        return op[4:2] == 3'b101;
    endfunction

    // Operand a is interpreted as two's complement
    function automatic logic op_signed_a(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Operand b is interpreted as two's complement
    function automatic logic op_signed_b(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one bit per step on operand magnitudes,
// sign correction applied on the final step. Divider half built only when
// ALU_MDU_DIV_EN is defined.
module mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last_c,
    output logic [XLEN-1:0] res_c
);

    localparam int unsigned SHW = $clog2(XLEN);

    // hi: product high half / partial remainder; lo: multiplier / dividend->quotient
    logic [XLEN-1:0]   hi_q, lo_q, m_q, hi_d, lo_d;
    logic [1:0]        sel_q;
    logic              neg_q;
    logic [SHW-1:0]    cnt_q;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod;
`ifdef ALU_MDU_DIV_EN
    logic              div_q, rneg_q;
    logic [XLEN:0]     rsh, diff;
`endif

    // Operand magnitudes for the op being started
    always_comb begin
        a_neg = a[XLEN-1] && op_signed_a(op);
        b_neg = b[XLEN-1] && op_signed_b(op);
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One shift-add (mul) or restoring-subtract (div) step
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
`ifdef ALU_MDU_DIV_EN
        rsh  = {hi_q, lo_q[XLEN-1]};
        diff = rsh - {1'b0, m_q};
        if (div_q) begin
            if (!diff[XLEN]) begin
                hi_d = diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = rsh[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    // Final sign correction and half/quotient/remainder selection
    always_comb begin
        prod = {hi_d, lo_d};
        if (neg_q) begin
            prod = -prod;
        end
        res_c = (sel_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
        if (div_q) begin
            if (sel_q[1]) begin
                res_c = rneg_q ? -hi_d : hi_d;
            end else begin
                res_c = neg_q ? -lo_d : lo_d;
            end
        end
`endif
    end

    assign last_c = step && (cnt_q == SHW'(XLEN - 1));

    // Operand capture on start, one iteration per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            m_q    <= '0;
            sel_q  <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
`ifdef ALU_MDU_DIV_EN
            div_q  <= 1'b0;
            rneg_q <= 1'b0;
`endif
        end else if (start) begin
            hi_q   <= '0;
            lo_q   <= a_mag;
            m_q    <= b_mag;
            sel_q  <= op[1:0];
            neg_q  <= a_neg ^ b_neg;
            cnt_q  <= '0;
`ifdef ALU_MDU_DIV_EN
            div_q  <= is_div(op);
            rneg_q <= a_neg;
`endif
        end else if (step) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            cnt_q  <= cnt_q + SHW'(1);
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with iterative multiply/divide behind a valid/ready handshake.
// Optional divider: define ALU_MDU_DIV_EN to build DIV/DIVU/REM/REMU.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);

    mdu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_d, alu_res_c, mdu_res_c;
    logic            illegal_d, alu_ill_c;
    logic            accept_c, start_c, step_c, last_c;
    logic [SHW-1:0]  shamt_c;

    assign in_ready = ((state_q == IDLE) || ((state_q == DONE) && out_ready)) && !flush;
    assign step_c   = (state_q == MUL) || (state_q == DIV);

    mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_c),
        .step   (step_c),
        .op     (op),
        .a      (a),
        .b      (b),
        .last_c (last_c),
        .res_c  (mdu_res_c)
    );

    // Single-cycle ALU; unknown codes flag illegal with a zero result
    always_comb begin
        shamt_c   = b[SHW-1:0];
        alu_res_c = '0;
        alu_ill_c = 1'b0;
        case (op)
            OP_ADD:   alu_res_c = a + b;
            OP_SUB:   alu_res_c = a - b;
            OP_SLL:   alu_res_c = a << shamt_c;
            OP_SLT:   alu_res_c = XLEN'($signed(a) < $signed(b));
            OP_SLTU:  alu_res_c = XLEN'(a < b);
            OP_XOR:   alu_res_c = a ^ b;
            OP_SRL:   alu_res_c = a >> shamt_c;
            OP_SRA:   alu_res_c = $unsigned($signed(a) >>> shamt_c);
            OP_OR:    alu_res_c = a | b;
            OP_AND:   alu_res_c = a & b;
            OP_PASSB: alu_res_c = b;
            default:  alu_ill_c = 1'b1;
        endcase
    end

    // Next state and result; flush overrides everything
    always_comb begin
        state_d   = state_q;
        result_d  = result;
        illegal_d = illegal;
        start_c   = 1'b0;
        accept_c  = in_valid && in_ready;
        case (state_q)
            MUL, DIV: begin
                if (last_c) begin
                    state_d   = DONE;
                    result_d  = mdu_res_c;
                    illegal_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        if (accept_c) begin
            state_d   = DONE;
            result_d  = alu_res_c;
            illegal_d = alu_ill_c;
            if (is_mul(op)) begin
                state_d   = MUL;
                illegal_d = 1'b0;
                start_c   = 1'b1;
            end
`ifdef ALU_MDU_DIV_EN
            else if (is_div(op)) begin
                illegal_d = 1'b0;
                if (b == '0) begin
                    // divide by zero resolves immediately: quotient all ones, remainder a
                    result_d = op[1] ? a : '1;
                end else begin
                    state_d = DIV;
                    start_c = 1'b1;
                end
            end
`endif
        end
        if (flush) begin
            state_d = IDLE;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            illegal   <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d == DONE);
            busy      <= (state_d == MUL) || (state_d == DIV);
            result    <= result_d;
            illegal   <= illegal_d;
        end
    end

endmodule
